// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
// Moore-style control FSM for a multicycle RV32I-subset core (lw, sw, R-type,
// I-type, beq, jal) with one shared ALU and one unified memory port.
// Fetch and data accesses stall on the mem_ready handshake.
// Build option: define MC_CTRL_ILLEGAL_TRAP_EN so that an illegal opcode
// parks the FSM in TRAP. Without it, an illegal opcode retires as a no-op.
module multicycle_ctrl (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pcwrite,
   output logic       adrsrc,
   output logic       irwrite,
   output logic       memwrite,
   output logic       regwrite,
   output logic [1:0] resultsrc,
   output logic [1:0] alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] immsrc,
   output logic [2:0] alucontrol,
   output logic       retire,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECUTER = 4'd6,
      ALUWB    = 4'd7,
      EXECUTEI = 4'd8,
      JAL      = 4'd9,
      BEQ      = 4'd10
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      ,
      TRAP     = 4'd11
`endif
   } state_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   state_t     state_q, state_d;
   logic [2:0] funct_alu;

   assign state = state_q;

   // State register; reset returns the FSM to FETCH.
   always_ff @(posedge clk) begin
      if (reset) state_q <= FETCH;
      else       state_q <= state_d;
   end

   // ALU operation for R-type / I-type execute; subtract only for R-type with funct7 set.
   always_comb begin
      funct_alu = ALU_ADD;
      case (funct3)
         3'b000:  funct_alu = (opcode[5] & funct7) ? ALU_SUB : ALU_ADD;
         3'b010:  funct_alu = ALU_SLT;
         3'b110:  funct_alu = ALU_OR;
         3'b111:  funct_alu = ALU_AND;
         default: funct_alu = ALU_ADD;
      endcase
   end

   // Next-state and Moore outputs; strobes are gated off while reset is high.
   always_comb begin
      state_d    = state_q;
      pcwrite    = 1'b0;
      adrsrc     = 1'b0;
      irwrite    = 1'b0;
      memwrite   = 1'b0;
      regwrite   = 1'b0;
      resultsrc  = 2'b00;
      alusrca    = 2'b00;
      alusrcb    = 2'b00;
      immsrc     = 2'b00;
      alucontrol = ALU_ADD;
      retire     = 1'b0;

      case (state_q)
         FETCH: begin
            alusrcb   = 2'b10;
            resultsrc = 2'b10;
            if (mem_ready) begin
               irwrite = 1'b1;
               pcwrite = 1'b1;
               state_d = DECODE;
            end
         end
         DECODE: begin
            alusrca = 2'b01;
            alusrcb = 2'b01;
            immsrc  = 2'b10;
            case (opcode)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_R:         state_d = EXECUTER;
               OP_I:         state_d = EXECUTEI;
               OP_BEQ:       state_d = BEQ;
               OP_JAL:       state_d = JAL;
               default: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                  state_d = TRAP;
`else
                  retire  = 1'b1;
                  state_d = FETCH;
`endif
               end
            endcase
         end
         MEMADR: begin
            alusrca = 2'b10;
            alusrcb = 2'b01;
            immsrc  = opcode[5] ? 2'b01 : 2'b00;
            state_d = opcode[5] ? MEMWRITE : MEMREAD;
         end
         MEMREAD: begin
            adrsrc = 1'b1;
            if (mem_ready) state_d = MEMWB;
         end
         MEMWB: begin
            resultsrc = 2'b01;
            regwrite  = 1'b1;
            retire    = 1'b1;
            state_d   = FETCH;
         end
         MEMWRITE: begin
            adrsrc   = 1'b1;
            memwrite = 1'b1;
            if (mem_ready) begin
               retire  = 1'b1;
               state_d = FETCH;
            end
         end
         EXECUTER: begin
            alusrca    = 2'b10;
            alucontrol = funct_alu;
            state_d    = ALUWB;
         end
         EXECUTEI: begin
            alusrca    = 2'b10;
            alusrcb    = 2'b01;
            alucontrol = funct_alu;
            state_d    = ALUWB;
         end
         ALUWB: begin
            regwrite = 1'b1;
            retire   = 1'b1;
            state_d  = FETCH;
         end
         JAL: begin
            // Link value computed here; the instruction retires in ALUWB.
            alusrca = 2'b01;
            alusrcb = 2'b10;
            pcwrite = 1'b1;
            immsrc  = 2'b11;
            state_d = ALUWB;
         end
         BEQ: begin
            alusrca    = 2'b10;
            alucontrol = ALU_SUB;
            pcwrite    = zero;
            retire     = 1'b1;
            state_d    = FETCH;
         end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
         TRAP: begin
            state_d = TRAP;
         end
`endif
         default: begin
            state_d = FETCH;
         end
      endcase

      if (reset) begin
         pcwrite  = 1'b0;
         irwrite  = 1'b0;
         memwrite = 1'b0;
         regwrite = 1'b0;
         retire   = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle state and strobe vectors.
// Strobe vector order: {pcwrite, adrsrc, irwrite, memwrite, regwrite, retire}.
module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] opcode = 7'b0110011;
   logic [2:0] funct3 = 3'b000;
   logic       funct7 = 1'b0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b1;
   logic       pcwrite, adrsrc, irwrite, memwrite, regwrite, retire;
   logic [1:0] resultsrc, alusrca, alusrcb, immsrc;
   logic [2:0] alucontrol;
   logic [3:0] state;
   logic [5:0] strb;

   int n_checks = 0;
   int n_fail   = 0;

   multicycle_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .opcode     (opcode),
      .funct3     (funct3),
      .funct7     (funct7),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .pcwrite    (pcwrite),
      .adrsrc     (adrsrc),
      .irwrite    (irwrite),
      .memwrite   (memwrite),
      .regwrite   (regwrite),
      .resultsrc  (resultsrc),
      .alusrca    (alusrca),
      .alusrcb    (alusrcb),
      .immsrc     (immsrc),
      .alucontrol (alucontrol),
      .retire     (retire),
      .state      (state)
   );

   assign strb = {pcwrite, adrsrc, irwrite, memwrite, regwrite, retire};

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock cycle: apply inputs after the falling edge, check shortly after.
   task automatic cyc(input string tag, input logic rst, input logic [6:0] op,
                      input logic [2:0] f3, input logic f7, input logic z, input logic mr,
                      input logic [3:0] est, input logic [5:0] estr);
      @(negedge clk);
      reset = rst; opcode = op; funct3 = f3; funct7 = f7; zero = z; mem_ready = mr;
      #1;
      check_val({tag, ".state"}, 32'(state), 32'(est));
      check_val({tag, ".strb"}, 32'(strb), 32'(estr));
   endtask

   // FETCH + DECODE; mem_ready is low during DECODE to show it is ignored there.
   task automatic fetch_decode(input string tag, input logic [6:0] op, input logic [2:0] f3,
                               input logic f7, input logic z);
      cyc({tag, ".F"}, 1'b0, op, f3, f7, z, 1'b1, 4'd0, 6'b101000);
      check_val({tag, ".F.srcb"}, 32'(alusrcb), 32'd2);
      check_val({tag, ".F.res"}, 32'(resultsrc), 32'd2);
      cyc({tag, ".D"}, 1'b0, op, f3, f7, z, 1'b0, 4'd1, 6'b000000);
      check_val({tag, ".D.srca"}, 32'(alusrca), 32'd1);
      check_val({tag, ".D.imm"}, 32'(immsrc), 32'd2);
   endtask

   task automatic run_alu(input string tag, input logic [6:0] op, input logic [2:0] f3,
                          input logic f7, input logic [3:0] exst, input logic [1:0] esrcb,
                          input logic [2:0] ealu);
      fetch_decode(tag, op, f3, f7, 1'b0);
      cyc({tag, ".X"}, 1'b0, op, f3, f7, 1'b0, 1'b1, exst, 6'b000000);
      check_val({tag, ".X.alu"}, 32'(alucontrol), 32'(ealu));
      check_val({tag, ".X.srca"}, 32'(alusrca), 32'd2);
      check_val({tag, ".X.srcb"}, 32'(alusrcb), 32'(esrcb));
      cyc({tag, ".WB"}, 1'b0, op, f3, f7, 1'b0, 1'b1, 4'd7, 6'b000011);
      check_val({tag, ".WB.res"}, 32'(resultsrc), 32'd0);
   endtask

   initial begin
      // reset held with an R-type opcode present
      cyc("rst", 1'b1, 7'b0110011, 3'b000, 1'b0, 1'b0, 1'b1, 4'd0, 6'b000000);
      cyc("rst2", 1'b1, 7'b0110011, 3'b000, 1'b0, 1'b0, 1'b1, 4'd0, 6'b000000);

      // R-type and I-type funct decode
      run_alu("add",  7'b0110011, 3'b000, 1'b0, 4'd6, 2'b00, 3'b000);
      run_alu("sub",  7'b0110011, 3'b000, 1'b1, 4'd6, 2'b00, 3'b001);
      run_alu("slt",  7'b0110011, 3'b010, 1'b0, 4'd6, 2'b00, 3'b101);
      run_alu("or",   7'b0110011, 3'b110, 1'b0, 4'd6, 2'b00, 3'b011);
      run_alu("and",  7'b0110011, 3'b111, 1'b0, 4'd6, 2'b00, 3'b010);
      run_alu("r001", 7'b0110011, 3'b001, 1'b0, 4'd6, 2'b00, 3'b000);
      run_alu("addi", 7'b0010011, 3'b000, 1'b1, 4'd8, 2'b01, 3'b000);
      run_alu("ori",  7'b0010011, 3'b110, 1'b0, 4'd8, 2'b01, 3'b011);

      // FETCH stall then lw with two wait cycles in MEMREAD
      cyc("fst", 1'b0, 7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 4'd0, 6'b000000);
      fetch_decode("lw", 7'b0000011, 3'b010, 1'b0, 1'b0);
      cyc("lw.A", 1'b0, 7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 4'd2, 6'b000000);
      check_val("lw.A.imm", 32'(immsrc), 32'd0);
      check_val("lw.A.srcb", 32'(alusrcb), 32'd1);
      cyc("lw.R1", 1'b0, 7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 4'd3, 6'b010000);
      cyc("lw.R2", 1'b0, 7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 4'd3, 6'b010000);
      cyc("lw.R3", 1'b0, 7'b0000011, 3'b010, 1'b0, 1'b0, 1'b1, 4'd3, 6'b010000);
      cyc("lw.WB", 1'b0, 7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 4'd4, 6'b000011);
      check_val("lw.WB.res", 32'(resultsrc), 32'd1);

      // sw with one wait cycle
      fetch_decode("sw", 7'b0100011, 3'b010, 1'b0, 1'b0);
      cyc("sw.A", 1'b0, 7'b0100011, 3'b010, 1'b0, 1'b0, 1'b1, 4'd2, 6'b000000);
      check_val("sw.A.imm", 32'(immsrc), 32'd1);
      cyc("sw.W1", 1'b0, 7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 4'd5, 6'b010100);
      cyc("sw.W2", 1'b0, 7'b0100011, 3'b010, 1'b0, 1'b0, 1'b1, 4'd5, 6'b010101);

      // beq taken and not taken
      fetch_decode("beqT", 7'b1100011, 3'b000, 1'b0, 1'b1);
      cyc("beqT.B", 1'b0, 7'b1100011, 3'b000, 1'b0, 1'b1, 1'b1, 4'd10, 6'b100001);
      check_val("beqT.B.alu", 32'(alucontrol), 32'd1);
      fetch_decode("beqN", 7'b1100011, 3'b000, 1'b0, 1'b0);
      cyc("beqN.B", 1'b0, 7'b1100011, 3'b000, 1'b0, 1'b0, 1'b1, 4'd10, 6'b000001);

      // jal: retire lands in ALUWB, not JAL
      fetch_decode("jal", 7'b1101111, 3'b000, 1'b0, 1'b0);
      cyc("jal.J", 1'b0, 7'b1101111, 3'b000, 1'b0, 1'b0, 1'b1, 4'd9, 6'b100000);
      check_val("jal.J.imm", 32'(immsrc), 32'd3);
      check_val("jal.J.srcb", 32'(alusrcb), 32'd2);
      cyc("jal.WB", 1'b0, 7'b1101111, 3'b000, 1'b0, 1'b0, 1'b1, 4'd7, 6'b000011);

      // reset in the middle of a stalled store
      fetch_decode("swr", 7'b0100011, 3'b010, 1'b0, 1'b0);
      cyc("swr.A", 1'b0, 7'b0100011, 3'b010, 1'b0, 1'b0, 1'b1, 4'd2, 6'b000000);
      cyc("swr.W", 1'b0, 7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0, 4'd5, 6'b010100);
      cyc("swr.R", 1'b1, 7'b0100011, 3'b010, 1'b0, 1'b0, 1'b1, 4'd5, 6'b010000);
      cyc("swr.R2", 1'b1, 7'b0100011, 3'b010, 1'b0, 1'b0, 1'b1, 4'd0, 6'b000000);

      // illegal opcode
      cyc("ill.F", 1'b0, 7'b1111111, 3'b000, 1'b0, 1'b0, 1'b1, 4'd0, 6'b101000);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      cyc("ill.D", 1'b0, 7'b1111111, 3'b000, 1'b0, 1'b0, 1'b1, 4'd1, 6'b000000);
      for (int i = 0; i < 20; i++)
         cyc("ill.T", 1'b0, 7'b1111111, 3'b000, 1'b0, 1'b1, 1'b1, 4'd11, 6'b000000);
      cyc("ill.R", 1'b1, 7'b1111111, 3'b000, 1'b0, 1'b0, 1'b1, 4'd11, 6'b000000);
      cyc("ill.R2", 1'b1, 7'b0110011, 3'b000, 1'b0, 1'b0, 1'b1, 4'd0, 6'b000000);
`else
      cyc("ill.D", 1'b0, 7'b1111111, 3'b000, 1'b0, 1'b0, 1'b1, 4'd1, 6'b000001);
      cyc("ill.F2", 1'b0, 7'b1111111, 3'b000, 1'b0, 1'b0, 1'b1, 4'd0, 6'b101000);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
